// File: rtl/crc32_pkg.sv
// Shared CRC32 constants and context type for the channel arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package crc32_pkg;

   localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_XOROUT    = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;

   typedef logic [31:0] crc32_t;

endpackage

// File: rtl/crc32_byte_step.sv
// One reflected CRC32 byte update (bit 0 of the byte enters first).
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module crc32_byte_step
   import crc32_pkg::*;
(
   input  crc32_t     crc_in,
   input  logic [7:0] data,
   output crc32_t     crc_out
);

   crc32_t c;

   // Fold the byte into the low bits, then shift out eight bits LSB-first.
   always_comb begin
      c = crc_in ^ {24'h000000, data};
      for (int b = 0; b < 8; b++) begin
         c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
      end
      crc_out = c;
   end

endmodule

// File: rtl/crc32_chan_arbiter.sv
// Round-robin sharing of one CRC32 byte engine among N_CH requesters, one context each.
// Latency: last byte accepted -> res_valid one cycle later; 1 byte/cycle aggregate.
// Backpressure: last bytes stall while the result slot is full; optional length via CRC32_ARB_LEN_EN.
module crc32_chan_arbiter
   import crc32_pkg::*;
#(
   parameter int N_CH = 4,
   parameter int CH_W = $clog2(N_CH)
)
(
   input  logic                clk,
   input  logic                reset,
   input  logic [N_CH-1:0]     req_valid,
   input  logic [N_CH*8-1:0]   req_data,
   input  logic [N_CH-1:0]     req_last,
   output logic [N_CH-1:0]     req_ready,
   input  logic [N_CH-1:0]     clr,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [CH_W-1:0]     res_chan,
   output crc32_t              res_crc,
   output logic [15:0]         res_len,
   output logic                busy
);

   crc32_t            ctx [N_CH];
   logic [CH_W-1:0]   rr_ptr;
   logic [CH_W-1:0]   gnt_idx;
   logic              gnt_any;
   logic [N_CH-1:0]   eligible;
   logic              res_full;
   int                scan;
   crc32_t            sel_ctx;
   crc32_t            nxt;
   logic [7:0]        sel_byte;
   logic              sel_last;

   // The result slot counts as free in the very cycle it is being consumed.
   assign res_full = res_valid & ~res_ready;
   assign eligible = req_valid & ~clr & ~(req_last & {N_CH{res_full}});

   // Scan channels starting at rr_ptr and take the first eligible one; nothing while in reset.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      scan    = 0;
      for (int j = 0; j < N_CH; j++) begin
         scan = (int'(rr_ptr) + j) % N_CH;
         if (!reset && !gnt_any && eligible[CH_W'(scan)]) begin
            gnt_any = 1'b1;
            gnt_idx = CH_W'(scan);
         end
      end
   end

   assign req_ready = gnt_any ? (N_CH'(1) << gnt_idx) : '0;

   assign sel_ctx  = ctx[gnt_idx];
   assign sel_byte = req_data[{gnt_idx, 3'b000} +: 8];
   assign sel_last = req_last[gnt_idx];

   crc32_byte_step u_step (
      .crc_in  (sel_ctx),
      .data    (sel_byte),
      .crc_out (nxt)
   );

   // Per-channel contexts: clear on abort, advance on grant, reseed after the last byte.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_CH; i++) ctx[i] <= CRC32_INIT;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (clr[i]) begin
               ctx[i] <= CRC32_INIT;
            end else if (gnt_any && gnt_idx == CH_W'(i)) begin
               ctx[i] <= sel_last ? CRC32_INIT : nxt;
            end
         end
      end
   end

   // Round-robin pointer moves just past the channel that was served.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr <= '0;
      end else if (gnt_any) begin
         rr_ptr <= (int'(gnt_idx) == N_CH - 1) ? '0 : gnt_idx + 1'b1;
      end
   end

   // Result register: a new completion reloads it even while the old one is being taken.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         res_valid <= 1'b0;
         res_chan  <= '0;
         res_crc   <= '0;
      end else if (gnt_any && sel_last) begin
         res_valid <= 1'b1;
         res_chan  <= gnt_idx;
         res_crc   <= nxt ^ CRC32_XOROUT;
      end else if (res_ready) begin
         res_valid <= 1'b0;
      end
   end

`ifdef CRC32_ARB_LEN_EN
   logic [15:0] cnt [N_CH];
   logic [15:0] cnt_inc;
   logic [15:0] len_q;

   assign cnt_inc = (cnt[gnt_idx] == 16'hFFFF) ? 16'hFFFF : cnt[gnt_idx] + 16'd1;

   // Saturating byte counters, zeroed by abort and after each completed packet.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (clr[i]) begin
               cnt[i] <= '0;
            end else if (gnt_any && gnt_idx == CH_W'(i)) begin
               cnt[i] <= sel_last ? 16'd0 : cnt_inc;
            end
         end
      end
   end

   // Length is latched alongside the CRC when a packet completes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         len_q <= '0;
      end else if (gnt_any && sel_last) begin
         len_q <= cnt_inc;
      end
   end

   assign res_len = len_q;
`else
   assign res_len = '0;
`endif

   // Busy while any packet is part-way through or a result is waiting.
   always_comb begin
      busy = res_valid;
      for (int i = 0; i < N_CH; i++) begin
         if (ctx[i] != CRC32_INIT) busy = 1'b1;
      end
   end

endmodule
